operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 128 ++++++++++++
 tb/tb_operand_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand loader: debounced enter button steps a, b and opcode into
// registers for the calculator datapath.
module operand_loader #(
  parameter int M  = 6,
  parameter int DB = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] sw,
  input  logic         btn,
  input  logic         clr,
  output logic [M-1:0] a,
  output logic [M-1:0] b,
  output logic [3:0]   sel,
  output logic         valid,
  output logic [1:0]   state
);

  localparam int CW = $clog2(DB + 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t          st_q;
  state_t          st_d;
  logic [M-1:0]    a_d;
  logic [M-1:0]    b_d;
  logic [3:0]      sel_d;
  logic            valid_d;

  logic            sync1;
  logic            btn_s;
  logic            armed;
  logic            armed_d;
  logic            tgt;
  logic            press;
  logic [CW-1:0]   run;
  logic [CW-1:0]   run_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  // sync1 is the level btn_s takes on this edge, so a run counts
  // the edge where btn_s changes; disarmed counts highs, armed lows.
  always_comb begin
    tgt     = ~armed;
    run_d   = '0;
    armed_d = armed;
    press   = 1'b0;
    if (sync1 == tgt) begin
      run_d = (btn_s == tgt) ? run + CW'(1) : CW'(1);
    end
    if (run_d == CW'(DB)) begin
      run_d   = '0;
      armed_d = ~armed;
      press   = ~armed;
    end
  end

  always_comb begin
    st_d    = st_q;
    a_d     = a;
    b_d     = b;
    sel_d   = sel;
    valid_d = valid;
    if (clr) begin
      st_d    = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = '0;
      valid_d = 1'b0;
    end else if (press) begin
      unique case (st_q)
        LOAD_A: begin
          a_d  = sw;
          st_d = LOAD_B;
        end
        LOAD_B: begin
          b_d  = sw;
          st_d = LOAD_OP;
        end
        LOAD_OP: begin
          sel_d   = sw[3:0];
          valid_d = 1'b1;
          st_d    = READY;
        end
        READY: begin
          valid_d = 1'b0;
          st_d    = LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= LOAD_A;
      a     <= '0;
      b     <= '0;
      sel   <= '0;
      valid <= 1'b0;
      run   <= '0;
      armed <= 1'b0;
    end else begin
      st_q  <= st_d;
      a     <= a_d;
      b     <= b_d;
      sel   <= sel_d;
      valid <= valid_d;
      run   <= run_d;
      armed <= armed_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: behavioural model checked every cycle,
// plus directed sequences with literal expectations.
module tb_operand_loader;

  localparam int M  = 6;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [M-1:0] sw  = '0;
  logic         btn = 1'b0;
  logic         clr = 1'b0;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic [3:0]   sel;
  logic         valid;
  logic [1:0]   state;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;
  bit run_cmp = 1'b0;

  operand_loader #(.M(M), .DB(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .clr(clr),
    .a(a), .b(b), .sel(sel), .valid(valid), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: btn_s seen at an edge is btn as sampled on the edge
  // before; runs of consecutive levels decide presses and re-arm.
  bit m_b1    = 1'b0;
  bit m_armed = 1'b0;
  int m_run   = 0;
  int m_a     = 0;
  int m_b     = 0;
  int m_sel   = 0;
  int m_st    = 0;

  always @(posedge clk or negedge rst) begin : mdl
    bit bs;
    bit pr;
    int r;
    bit arm;
    if (!rst) begin
      m_b1 <= 1'b0; m_armed <= 1'b0; m_run <= 0;
      m_a <= 0; m_b <= 0; m_sel <= 0; m_st <= 0;
    end else begin
      bs  = m_b1;
      pr  = 1'b0;
      r   = m_run;
      arm = m_armed;
      if (!arm) begin
        r = bs ? r + 1 : 0;
        if (r == DB) begin pr = 1'b1; arm = 1'b1; r = 0; end
      end else begin
        r = bs ? 0 : r + 1;
        if (r == DB) begin arm = 1'b0; r = 0; end
      end
      m_b1    <= btn;
      m_run   <= r;
      m_armed <= arm;
      if (clr) begin
        m_a <= 0; m_b <= 0; m_sel <= 0; m_st <= 0;
      end else if (pr) begin
        case (m_st)
          0: begin m_a <= int'(sw); m_st <= 1; end
          1: begin m_b <= int'(sw); m_st <= 2; end
          2: begin m_sel <= int'(sw) % 16; m_st <= 3; end
          default: m_st <= 0;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_a", 32'(a), 32'(m_a));
      chk("cmp_b", 32'(b), 32'(m_b));
      chk("cmp_sel", 32'(sel), 32'(m_sel));
      chk("cmp_state", 32'(state), 32'(m_st));
      chk("cmp_valid", 32'(valid), 32'(m_st == 3));
      chk("valid_eq_ready", 32'(valid), 32'(state == 2'd3));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [M-1:0] v);
    sw  = v;
    btn = 1'b1;
    tick(6);
    btn = 1'b0;
    tick(8);
  endtask

  initial begin
    tick(2);
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    rst = 1'b1;
    run_cmp = 1'b1;

    // full load: btn first sampled on edge 10, capture on edge 14
    while (cyc < 9) tick(1);
    sw  = 6'h15;
    btn = 1'b1;
    tick(4);
    chk("a_before_e14", 32'(a), 32'h0);
    tick(1);
    chk("a_after_e14", 32'(a), 32'h15);
    chk("state_after_a", 32'(state), 32'h1);
    tick(1);
    btn = 1'b0;
    tick(8);
    press(6'h2A);
    chk("b_load", 32'(b), 32'h2A);
    chk("state_load_op", 32'(state), 32'h2);
    press(6'h03);
    chk("sel_load", 32'(sel), 32'h3);
    chk("valid_ready", 32'(valid), 32'h1);
    chk("state_ready", 32'(state), 32'h3);

    // READY wrap
    press(6'h11);
    chk("wrap_valid", 32'(valid), 32'h0);
    chk("wrap_state", 32'(state), 32'h0);
    chk("wrap_b_kept", 32'(b), 32'h2A);
    chk("wrap_sel_kept", 32'(sel), 32'h3);
    press(6'h3F);
    chk("wrap_a", 32'(a), 32'h3F);

    // synchronous clear
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_a", 32'(a), 32'h0);
    chk("clr_state", 32'(state), 32'h0);

    // held button loads only a
    sw  = 6'h07;
    btn = 1'b1;
    tick(50);
    sw  = 6'h2C;
    tick(2);
    chk("held_state", 32'(state), 32'h1);
    chk("held_a", 32'(a), 32'h07);
    chk("held_b", 32'(b), 32'h0);
    btn = 1'b0;
    tick(8);
    press(6'h09);
    chk("held_repress_b", 32'(b), 32'h09);

    // clear on the edge a press is accepted in LOAD_OP
    sw  = 6'h05;
    btn = 1'b1;
    tick(4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("coll_state", 32'(state), 32'h0);
    chk("coll_sel", 32'(sel), 32'h0);
    chk("coll_b", 32'(b), 32'h0);
    tick(6);
    chk("coll_no_reaccept", 32'(state), 32'h0);
    btn = 1'b0;
    tick(8);

    // bounce: high 2 / low 1, then stable high
    sw = 6'h22;
    repeat (4) begin
      btn = 1'b1;
      tick(2);
      btn = 1'b0;
      tick(1);
    end
    chk("bounce_none", 32'(state), 32'h0);
    btn = 1'b1;
    tick(4);
    chk("bounce_early", 32'(state), 32'h0);
    tick(1);
    chk("bounce_capture", 32'(a), 32'h22);
    tick(3);
    btn = 1'b0;
    tick(8);

    // back to READY with a=15, then async reset
    press(6'h2A);
    press(6'h05);
    press(6'h00);
    press(6'h15);
    press(6'h2A);
    press(6'h05);
    chk("pre_rst_a", 32'(a), 32'h15);
    chk("pre_rst_state", 32'(state), 32'h3);
    #2 rst = 1'b0;
    #1;
    chk("async_a", 32'(a), 32'h0);
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_state", 32'(state), 32'h0);
    btn = 1'b1;
    sw  = 6'h0C;
    tick(3);
    rst = 1'b1;
    tick(4);
    chk("straddle_early", 32'(state), 32'h0);
    tick(1);
    chk("straddle_capture", 32'(a), 32'h0C);
    btn = 1'b0;
    tick(8);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
